time_base_ctrl: RTL and testbench
=================================

TIME_BASE_CTRL -- requirements
Module: time_base_ctrl

Interface
REQ-001 SHALL have parameter DEF_TIC_DIVIDE, default 24'h3D08FF, meaning the reset value of tic_divide (0.1 s TIC at 40 MHz).
REQ-002 SHALL have parameter DEF_ACCUM_DIVIDE, default 24'h004E1F, meaning the reset value of accum_divide (0.5 ms at 40 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the clock.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: host write strobe, one cycle per write.
REQ-006 SHALL have port wr_addr, input, 2 bits: 0 = TIC shadow, 1 = ACCUM shadow, 2 = control, 3 = ignored.
REQ-007 SHALL have port wr_data, input, 24 bits: write data. Control bit0 = force_apply; control bit1 = clear_counters.
REQ-008 SHALL have port pre_tic_enable, input, 1 bit: pre-TIC pulse from the time base.
REQ-009 SHALL have port tic_enable, input, 1 bit: TIC pulse from the time base.
REQ-010 SHALL have port accum_enable, input, 1 bit: accumulation interrupt pulse from the time base.
REQ-011 SHALL have port int_ack, input, 1 bit: host acknowledge of accum_int.
REQ-012 SHALL have port tic_divide, output, 24 bits: active TIC divide value driven to the time base.
REQ-013 SHALL have port accum_divide, output, 24 bits: active accumulation divide value driven to the time base.
REQ-014 SHALL have ports tic_pending and accum_pending, outputs, 1 bit each: the shadow value is not yet applied.
REQ-015 SHALL have port accum_int, output, 1 bit: sticky accumulation interrupt flag.
REQ-016 SHALL have port missed_count, output, 8 bits: accum_enable events that arrived while accum_int was still set.
REQ-017 SHALL have port tic_epoch, output, 16 bits: count of TIC events.

Function
REQ-018 Each divide channel (TIC, ACCUM) SHALL contain a 24-bit shadow register, a 24-bit active register and a two-state FSM: IDLE, PENDING.
REQ-019 A write to address 0 or 1 SHALL load the matching shadow register on that edge and move that channel to PENDING. This applies from either state; the last write wins.
REQ-020 In PENDING, on an edge where the channel event is high, the channel SHALL copy the pre-edge shadow value to the active register and return to IDLE.
- TIC channel event: pre_tic_enable.
- ACCUM channel event: accum_enable.
REQ-021 Active-register latency SHALL be 1 cycle: the new value is visible on tic_divide or accum_divide the cycle after the event. The time base reloads on the event edge with the old value, so the new period takes effect from the following reload.
REQ-022 If a shadow write and the channel event occur on the same edge:
- the event applies the pre-edge shadow only if the channel was already PENDING;
- the newly written value is stored and the channel ends in PENDING.
REQ-023 A control write with bit0 = 1 SHALL copy both shadows to their active registers and clear both pending flags on that edge. This overrides REQ-020 and REQ-022 for that edge.
REQ-024 tic_pending and accum_pending SHALL be high exactly when the channel FSM is in PENDING.
REQ-025 accum_int SHALL set on accum_enable and clear on int_ack. When both occur on the same edge, set wins.
REQ-026 On accum_enable with accum_int already set and int_ack low, missed_count SHALL increment, saturating at 8'hFF.
REQ-027 tic_epoch SHALL increment on each tic_enable, wrapping 16'hFFFF to 0.
REQ-028 A control write with bit1 = 1 SHALL zero tic_epoch and missed_count. This has priority over a simultaneous increment.
REQ-029 Writes to address 3 and control bits 23:2 SHALL have no effect.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rstn is low at an edge, the block SHALL set:
- tic_divide = DEF_TIC_DIVIDE and accum_divide = DEF_ACCUM_DIVIDE;
- both shadows equal to their defaults;
- both FSMs IDLE, both pending flags 0;
- accum_int = 0, missed_count = 0, tic_epoch = 0.
REQ-032 Reset SHALL override all inputs, including a simultaneous write or event. A pending update in progress SHALL be discarded.

Structure
REQ-033 A shared package (time_base_pkg) SHALL hold:
- the address codes (ADDR_TIC, ADDR_ACCUM, ADDR_CTRL);
- the control bit indices;
- the default divide constants;
- the FSM state typedef.
REQ-034 The shadow/active/FSM channel SHALL be a sub-module, tb_shadow_reg. It is parameterised by reset value and instantiated twice: once with pre_tic_enable as its event, once with accum_enable.

Verification
REQ-035 Deferred apply: reset, then write addr0 = 24'h0000FF.
- Required: tic_pending = 1 and tic_divide = 24'h3D08FF until pre_tic_enable.
- Cycle after pre_tic_enable: tic_divide = 24'h0000FF and tic_pending = 0.
REQ-036 Write/event collision: write addr1 = 24'h1000, then on the pre_tic_enable edge write addr1 = 24'h2000 with accum_enable high on that same edge.
- Required: accum_divide = 24'h1000 and accum_pending = 1.
- At the next accum_enable: accum_divide = 24'h2000.
REQ-037 Force apply: write addr0 = 5, addr1 = 7, then control = 1 with no events.
- Next cycle: tic_divide = 5, accum_divide = 7, both pending flags = 0.
REQ-038 Interrupt and missed events:
- 3 accum_enable pulses without int_ack -> accum_int = 1, missed_count = 2.
- int_ack coincident with a 4th pulse -> accum_int = 1, missed_count = 2.
- 300 further pulses without ack -> missed_count = 255.
REQ-039 Epoch wrap and clear:
- 65537 tic_enable pulses -> tic_epoch = 1.
- control = 2 coincident with tic_enable -> tic_epoch = 0.
REQ-040 Mid-update reset: write addr0 = 24'h10, then assert rstn low for 1 cycle before pre_tic_enable.
- Required: tic_pending = 0 and tic_divide = 24'h3D08FF after the next pre_tic_enable.

Source files
------------

// File: rtl/time_base_pkg.sv
// Shared constants and types for the time-base divide controller.
package time_base_pkg;
  localparam logic [1:0] ADDR_TIC   = 2'd0;
  localparam logic [1:0] ADDR_ACCUM = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  localparam int CTRL_FORCE_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam logic [23:0] DEF_TIC_DIVIDE_C   = 24'h3D08FF;
  localparam logic [23:0] DEF_ACCUM_DIVIDE_C = 24'h004E1F;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } chan_state_e;
endpackage

// File: rtl/time_base_ctrl_if.sv
// Host write bus into the time-base controller.
interface time_base_ctrl_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tb_shadow_reg.sv
// One divide channel: host shadow register, active register and a deferred-apply FSM
// that commits the shadow on the channel's reload event.
module tb_shadow_reg
  import time_base_pkg::*;
#(
  parameter logic [23:0] RST_VAL = 24'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [23:0] load_data,
  input  logic        force_apply,
  input  logic        event_i,
  output logic [23:0] active_o,
  output logic        pending_o
);
  chan_state_e state_q, state_d;
  logic [23:0] shadow_q, shadow_d;
  logic [23:0] active_q, active_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (force_apply) begin
      active_d = shadow_q;
      state_d  = ST_IDLE;
    end else begin
      // Event commits the pre-edge shadow; a coincident load re-arms with the new value.
      if (state_q == ST_PENDING && event_i) begin
        active_d = shadow_q;
        state_d  = ST_IDLE;
      end
      if (load) begin
        shadow_d = load_data;
        state_d  = ST_PENDING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = (state_q == ST_PENDING);
endmodule

// File: rtl/time_base_ctrl.sv
// Host-facing control for the time base: double-buffered divide values, sticky
// accumulation interrupt with missed-event count, and a TIC epoch counter.
module time_base_ctrl
  import time_base_pkg::*;
#(
  parameter logic [23:0] DEF_TIC_DIVIDE   = DEF_TIC_DIVIDE_C,
  parameter logic [23:0] DEF_ACCUM_DIVIDE = DEF_ACCUM_DIVIDE_C
) (
  input  logic               clk,
  input  logic               rstn,
  time_base_ctrl_if.slave    host,
  input  logic               pre_tic_enable,
  input  logic               tic_enable,
  input  logic               accum_enable,
  input  logic               int_ack,
  output logic [23:0]        tic_divide,
  output logic [23:0]        accum_divide,
  output logic               tic_pending,
  output logic               accum_pending,
  output logic               accum_int,
  output logic [7:0]         missed_count,
  output logic [15:0]        tic_epoch
);
  logic ctrl_wr, force_apply, clear_cnt;
  logic tic_load, accum_load;

  assign ctrl_wr     = host.wr_en && (host.wr_addr == ADDR_CTRL);
  assign force_apply = ctrl_wr && host.wr_data[CTRL_FORCE_BIT];
  assign clear_cnt   = ctrl_wr && host.wr_data[CTRL_CLEAR_BIT];
  assign tic_load    = host.wr_en && (host.wr_addr == ADDR_TIC);
  assign accum_load  = host.wr_en && (host.wr_addr == ADDR_ACCUM);

  tb_shadow_reg #(.RST_VAL(DEF_TIC_DIVIDE)) u_tic_chan (
    .clk        (clk),
    .rstn       (rstn),
    .load       (tic_load),
    .load_data  (host.wr_data),
    .force_apply(force_apply),
    .event_i    (pre_tic_enable),
    .active_o   (tic_divide),
    .pending_o  (tic_pending)
  );

  tb_shadow_reg #(.RST_VAL(DEF_ACCUM_DIVIDE)) u_accum_chan (
    .clk        (clk),
    .rstn       (rstn),
    .load       (accum_load),
    .load_data  (host.wr_data),
    .force_apply(force_apply),
    .event_i    (accum_enable),
    .active_o   (accum_divide),
    .pending_o  (accum_pending)
  );

  logic        accum_int_q, accum_int_d;
  logic [7:0]  missed_count_q, missed_count_d;
  logic [15:0] tic_epoch_q, tic_epoch_d;

  always_comb begin
    accum_int_d    = accum_int_q;
    missed_count_d = missed_count_q;
    tic_epoch_d    = tic_epoch_q;
    // A new event beats a coincident acknowledge.
    if (accum_enable)  accum_int_d = 1'b1;
    else if (int_ack)  accum_int_d = 1'b0;
    if (clear_cnt) begin
      missed_count_d = 8'h00;
      tic_epoch_d    = 16'h0000;
    end else begin
      if (accum_enable && accum_int_q && !int_ack && missed_count_q != 8'hFF)
        missed_count_d = missed_count_q + 8'd1;
      if (tic_enable)
        tic_epoch_d = tic_epoch_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      accum_int_q    <= 1'b0;
      missed_count_q <= 8'h00;
      tic_epoch_q    <= 16'h0000;
    end else begin
      accum_int_q    <= accum_int_d;
      missed_count_q <= missed_count_d;
      tic_epoch_q    <= tic_epoch_d;
    end
  end

  assign accum_int    = accum_int_q;
  assign missed_count = missed_count_q;
  assign tic_epoch    = tic_epoch_q;
endmodule

// File: tb/tb_time_base_ctrl.sv
// Scoreboard bench for time_base_ctrl: directed scenarios plus random traffic,
// expected state per cycle from a behavioural model, popped by a monitor.
module tb_time_base_ctrl;
  logic clk = 1'b0;
  logic rstn;
  logic pre_tic_enable, tic_enable, accum_enable, int_ack;
  logic [23:0] tic_divide, accum_divide;
  logic tic_pending, accum_pending, accum_int;
  logic [7:0] missed_count;
  logic [15:0] tic_epoch;

  always #5 clk = ~clk;

  time_base_ctrl_if hif ();

  time_base_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .host          (hif),
    .pre_tic_enable(pre_tic_enable),
    .tic_enable    (tic_enable),
    .accum_enable  (accum_enable),
    .int_ack       (int_ack),
    .tic_divide    (tic_divide),
    .accum_divide  (accum_divide),
    .tic_pending   (tic_pending),
    .accum_pending (accum_pending),
    .accum_int     (accum_int),
    .missed_count  (missed_count),
    .tic_epoch     (tic_epoch)
  );

  typedef struct packed {
    logic [23:0] td;
    logic [23:0] ad;
    logic        tp;
    logic        ap;
    logic        ai;
    logic [7:0]  mc;
    logic [15:0] ep;
  } obs_t;

  obs_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: index 0 = TIC channel, 1 = ACCUM channel.
  logic [23:0] m_sh[2];
  logic [23:0] m_act[2];
  bit          m_pend[2];
  bit          m_ai;
  int          m_mc;
  int          m_ep;

  task automatic step(input bit r_n, input bit we, input logic [1:0] a, input logic [23:0] d,
                      input bit pt, input bit t, input bit ae, input bit ack);
    bit ev[2];
    bit frc, clr;
    obs_t e;
    @(negedge clk);
    rstn = r_n; hif.wr_en = we; hif.wr_addr = a; hif.wr_data = d;
    pre_tic_enable = pt; tic_enable = t; accum_enable = ae; int_ack = ack;
    if (!r_n) begin
      m_sh[0] = 24'h3D08FF; m_act[0] = 24'h3D08FF;
      m_sh[1] = 24'h004E1F; m_act[1] = 24'h004E1F;
      m_pend[0] = 0; m_pend[1] = 0;
      m_ai = 0; m_mc = 0; m_ep = 0;
    end else begin
      ev[0] = pt; ev[1] = ae;
      frc = we && a == 2 && d[0];
      clr = we && a == 2 && d[1];
      for (int c = 0; c < 2; c++) begin
        if (frc) begin
          m_act[c] = m_sh[c]; m_pend[c] = 0;
        end else begin
          if (m_pend[c] && ev[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
          if (we && a == c) begin m_sh[c] = d; m_pend[c] = 1; end
        end
      end
      if (clr) begin
        m_mc = 0; m_ep = 0;
      end else begin
        if (ae && m_ai && !ack) m_mc = (m_mc < 255) ? m_mc + 1 : 255;
        if (t) m_ep = (m_ep + 1) % 65536;
      end
      if (ae) m_ai = 1; else if (ack) m_ai = 0;
    end
    e.td = m_act[0]; e.ad = m_act[1]; e.tp = m_pend[0]; e.ap = m_pend[1];
    e.ai = m_ai; e.mc = m_mc[7:0]; e.ep = m_ep[15:0];
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 2'd0, 24'h0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    step(1, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expected record per clock edge driven by the stimulus.
  initial begin
    obs_t o, e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = '{td: tic_divide, ad: accum_divide, tp: tic_pending, ap: accum_pending,
              ai: accum_int, mc: missed_count, ep: tic_epoch};
        n_chk++;
        if (o !== e) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL scoreboard @%0t: got td=%h ad=%h tp=%b ap=%b ai=%b mc=%0d ep=%0d expected td=%h ad=%h tp=%b ap=%b ai=%b mc=%0d ep=%0d",
                     $time, o.td, o.ad, o.tp, o.ap, o.ai, o.mc, o.ep,
                     e.td, e.ad, e.tp, e.ap, e.ai, e.mc, e.ep);
        end
      end
    end
  end

  initial begin
    int waited;
    rstn = 0; hif.wr_en = 0; hif.wr_addr = 0; hif.wr_data = 0;
    pre_tic_enable = 0; tic_enable = 0; accum_enable = 0; int_ack = 0;

    // Reset, with a write and events asserted to show reset overrides them.
    step(0, 1, 2'd0, 24'h123456, 1, 1, 1, 0);
    step(0, 0, 2'd0, 24'h0, 0, 0, 0, 0);
    settle();
    chk("reset_tic_divide", tic_divide, 24'h3D08FF);
    chk("reset_accum_divide", accum_divide, 24'h004E1F);
    chk("reset_pending", {tic_pending, accum_pending, accum_int}, 0);
    chk("reset_counts", {missed_count, tic_epoch}, 0);

    // Deferred apply
    wr(2'd0, 24'h0000FF);
    repeat (4) idle();
    settle();
    chk("defer_pending", tic_pending, 1);
    chk("defer_old_divide", tic_divide, 24'h3D08FF);
    step(1, 0, 2'd0, 24'h0, 1, 0, 0, 0);
    settle();
    chk("defer_applied", tic_divide, 24'h0000FF);
    chk("defer_cleared", tic_pending, 0);

    // Write/event collision on the ACCUM channel
    wr(2'd1, 24'h001000);
    step(1, 1, 2'd1, 24'h002000, 1, 0, 1, 0);
    settle();
    chk("collide_divide", accum_divide, 24'h001000);
    chk("collide_pending", accum_pending, 1);
    step(1, 0, 2'd0, 24'h0, 0, 0, 1, 0);
    settle();
    chk("collide_next_event", accum_divide, 24'h002000);

    // Force apply, plus ignored address 3 and upper control bits
    wr(2'd0, 24'd5);
    wr(2'd1, 24'd7);
    wr(2'd3, 24'hFFFFFF);
    wr(2'd2, 24'hFFFFFC);
    wr(2'd2, 24'd1);
    settle();
    chk("force_tic", tic_divide, 24'd5);
    chk("force_accum", accum_divide, 24'd7);
    chk("force_pending", {tic_pending, accum_pending}, 0);

    // Interrupt and missed events
    step(1, 0, 2'd0, 24'h0, 0, 0, 0, 1);
    wr(2'd2, 24'd2);
    repeat (3) step(1, 0, 2'd0, 24'h0, 0, 0, 1, 0);
    settle();
    chk("int_set", accum_int, 1);
    chk("missed_2", missed_count, 2);
    step(1, 0, 2'd0, 24'h0, 0, 0, 1, 1);
    settle();
    chk("int_ack_loses", accum_int, 1);
    chk("missed_hold", missed_count, 2);
    repeat (300) step(1, 0, 2'd0, 24'h0, 0, 0, 1, 0);
    settle();
    chk("missed_sat", missed_count, 255);

    // Epoch wrap and clear
    wr(2'd2, 24'd2);
    repeat (65537) step(1, 0, 2'd0, 24'h0, 0, 1, 0, 0);
    settle();
    chk("epoch_wrap", tic_epoch, 1);
    step(1, 1, 2'd2, 24'd2, 0, 1, 0, 0);
    settle();
    chk("epoch_clear", tic_epoch, 0);

    // Mid-update reset
    wr(2'd0, 24'h000010);
    step(0, 0, 2'd0, 24'h0, 0, 0, 0, 0);
    step(1, 0, 2'd0, 24'h0, 1, 0, 0, 0);
    settle();
    chk("midreset_pending", tic_pending, 0);
    chk("midreset_divide", tic_divide, 24'h3D08FF);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic [23:0] d;
      a = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 3));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), a, d,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk); #2;
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
